// File: rtl/bp_detect_pkg.sv
// Shared types and width helpers for the band energy detector.
package bp_detect_pkg;

    typedef enum logic [1:0] {
        QUIET,
        ACTIVE,
        HOLDOFF
    } det_state_t;

    function automatic int acc_width(input int sig_w, input int win_log2);
        return sig_w + win_log2;
    endfunction

    // Holdoff counter must stay at least 1 bit wide when holdoff is disabled.
    function automatic int hold_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/window_accumulator.sv
// Sums |x| over 2**WIN_LOG2 valid samples and publishes the truncated mean
// with a one-cycle strobe when each window closes.
module window_accumulator
    import bp_detect_pkg::*;
#(
    parameter int SIG_WIDTH = 9,
    parameter int WIN_LOG2  = 6
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic signed [SIG_WIDTH-1:0] x_i,
    input  logic                        valid_i,
    output logic        [SIG_WIDTH-1:0] energy_o,
    output logic                        energy_valid_o
);

    localparam int ACC_W = acc_width(SIG_WIDTH, WIN_LOG2);

    logic [SIG_WIDTH-1:0] x_u;
    logic [SIG_WIDTH-1:0] mag;
    logic [ACC_W-1:0]     sum;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [WIN_LOG2-1:0]  cnt_q, cnt_d;
    logic [SIG_WIDTH-1:0] energy_q, energy_d;
    logic                 valid_q, valid_d;

    // Most negative input negates to 2**(SIG_WIDTH-1), which fits unsigned.
    always_comb begin
        x_u = x_i;
        mag = x_u[SIG_WIDTH-1] ? (~x_u + SIG_WIDTH'(1)) : x_u;
        sum = acc_q + ACC_W'(mag);
    end

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        energy_d = energy_q;
        valid_d  = 1'b0;
        if (valid_i) begin
            cnt_d = cnt_q + WIN_LOG2'(1);
            if (cnt_q == '1) begin
                acc_d    = '0;
                energy_d = SIG_WIDTH'(sum >> WIN_LOG2);
                valid_d  = 1'b1;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            energy_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            energy_q <= energy_d;
            valid_q  <= valid_d;
        end
    end

    assign energy_o       = energy_q;
    assign energy_valid_o = valid_q;

endmodule

// File: rtl/band_energy_detector.sv
// Windowed mean-|x| energy with a hysteresis/holdoff FSM producing a
// detect level and a one-cycle onset pulse.
module band_energy_detector
    import bp_detect_pkg::*;
#(
    parameter int SIG_WIDTH   = 9,
    parameter int WIN_LOG2    = 6,
    parameter int HOLDOFF_WIN = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic signed [SIG_WIDTH-1:0] x_in,
    input  logic                        x_in_valid,
    input  logic        [SIG_WIDTH-1:0] thresh_on_in,
    input  logic        [SIG_WIDTH-1:0] thresh_off_in,
    output logic        [SIG_WIDTH-1:0] energy_out,
    output logic                        energy_valid,
    output logic                        detect_out,
    output logic                        onset_out
);

    localparam int HOLD_W = hold_width(HOLDOFF_WIN);

    logic [SIG_WIDTH-1:0] energy;
    logic                 win_valid;
    det_state_t           state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 onset_q, onset_d;
    logic                 detect_q;

    window_accumulator #(
        .SIG_WIDTH (SIG_WIDTH),
        .WIN_LOG2  (WIN_LOG2)
    ) u_win (
        .clk_i          (clk_in),
        .rst_n_i        (rst_n_in),
        .x_i            (x_in),
        .valid_i        (x_in_valid),
        .energy_o       (energy),
        .energy_valid_o (win_valid)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        onset_d = 1'b0;
        if (win_valid) begin
            unique case (state_q)
                QUIET: begin
                    if (energy >= thresh_on_in) begin
                        state_d = ACTIVE;
                        onset_d = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (energy < thresh_off_in) begin
                        if (HOLDOFF_WIN == 0) begin
                            state_d = QUIET;
                        end else begin
                            state_d = HOLDOFF;
                            hold_d  = HOLD_W'(HOLDOFF_WIN);
                        end
                    end
                end
                HOLDOFF: begin
                    // Energy is ignored here; only window count matters.
                    if (hold_q <= HOLD_W'(1)) begin
                        state_d = QUIET;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = QUIET;
                    hold_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= QUIET;
            hold_q   <= '0;
            onset_q  <= 1'b0;
            detect_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            onset_q  <= onset_d;
            detect_q <= (state_d == ACTIVE);
        end
    end

    assign energy_out   = energy;
    assign energy_valid = win_valid;
    assign detect_out   = detect_q;
    assign onset_out    = onset_q;

endmodule

// File: tb/tb_band_energy_detector.sv
// Directed self-checking bench for band_energy_detector.
module tb_band_energy_detector;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [8:0] x = '0;
    logic              x_valid = 1'b0;
    logic        [8:0] th_on = 9'd80;
    logic        [8:0] th_off = 9'd40;
    logic        [8:0] energy;
    logic              e_valid;
    logic              detect;
    logic              onset;

    int tests = 0;
    int fails = 0;
    int ev_cnt = 0;
    int on_cnt = 0;

    band_energy_detector #(
        .SIG_WIDTH   (9),
        .WIN_LOG2    (6),
        .HOLDOFF_WIN (2)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .x_in          (x),
        .x_in_valid    (x_valid),
        .thresh_on_in  (th_on),
        .thresh_off_in (th_off),
        .energy_out    (energy),
        .energy_valid  (e_valid),
        .detect_out    (detect),
        .onset_out     (onset)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (e_valid) ev_cnt++;
        if (onset) on_cnt++;
    end

    // Drives n samples alternating a/b; returns at the negedge where the
    // window-close strobe of the last sample (if any) is visible.
    task automatic feed(input int a, input int b, input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
            repeat (g) begin
                @(negedge clk);
                x_valid = 1'b0;
            end
            @(negedge clk);
            x = 9'((i % 2) ? b : a);
            x_valid = 1'b1;
        end
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({energy, e_valid, detect, onset} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: got e=%0d v=%0b d=%0b o=%0b want all 0",
                     energy, e_valid, detect, onset);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_onset(input int maxgap, input string tag);
        int ev0, on0;
        ev0 = ev_cnt;
        on0 = on_cnt;
        feed(100, -100, 64, maxgap);
        tests++;
        if (e_valid !== 1'b1 || energy !== 9'd100) begin
            fails++;
            $display("FAIL %s_close: got v=%0b e=%0d want v=1 e=100", tag, e_valid, energy);
        end
        tests++;
        if (onset !== 1'b0 || detect !== 1'b0) begin
            fails++;
            $display("FAIL %s_early: got o=%0b d=%0b want 0 0", tag, onset, detect);
        end
        @(negedge clk);
        tests++;
        if (onset !== 1'b1 || detect !== 1'b1 || e_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_onset: got o=%0b d=%0b v=%0b want 1 1 0",
                     tag, onset, detect, e_valid);
        end
        @(negedge clk);
        tests++;
        if (onset !== 1'b0 || detect !== 1'b1) begin
            fails++;
            $display("FAIL %s_after: got o=%0b d=%0b want 0 1", tag, onset, detect);
        end
        tests++;
        if (ev_cnt - ev0 != 1 || on_cnt - on0 != 1) begin
            fails++;
            $display("FAIL %s_pulses: got ev=%0d on=%0d want 1 1",
                     tag, ev_cnt - ev0, on_cnt - on0);
        end
    endtask

    task automatic test_holdoff();
        int on0;
        feed(0, 0, 64, 0);
        tests++;
        if (e_valid !== 1'b1 || energy !== 9'd0) begin
            fails++;
            $display("FAIL hold_zero: got v=%0b e=%0d want 1 0", e_valid, energy);
        end
        @(negedge clk);
        tests++;
        if (detect !== 1'b0 || onset !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: got d=%0b o=%0b want 0 0", detect, onset);
        end
        on0 = on_cnt;
        for (int w = 0; w < 2; w++) begin
            feed(100, -100, 64, 0);
            @(negedge clk);
            tests++;
            if (detect !== 1'b0 || onset !== 1'b0 || energy !== 9'd100) begin
                fails++;
                $display("FAIL hold_ignore%0d: got d=%0b o=%0b e=%0d want 0 0 100",
                         w, detect, onset, energy);
            end
        end
        feed(100, -100, 64, 0);
        @(negedge clk);
        tests++;
        if (detect !== 1'b1 || onset !== 1'b1 || on_cnt != on0) begin
            fails++;
            $display("FAIL hold_rearm: got d=%0b o=%0b on=%0d want 1 1 %0d",
                     detect, onset, on_cnt - on0, 0);
        end
    endtask

    task automatic test_extremes();
        feed(-256, -256, 64, 0);
        tests++;
        if (energy !== 9'd256) begin
            fails++;
            $display("FAIL ext_neg: got %0d want 256", energy);
        end
        feed(255, 255, 64, 0);
        tests++;
        if (energy !== 9'd255) begin
            fails++;
            $display("FAIL ext_pos: got %0d want 255", energy);
        end
        feed(101, -100, 64, 0);
        tests++;
        if (energy !== 9'd100) begin
            fails++;
            $display("FAIL ext_trunc: got %0d want 100", energy);
        end
        repeat (10) @(negedge clk);
        tests++;
        if (energy !== 9'd100 || e_valid !== 1'b0 || detect !== 1'b1) begin
            fails++;
            $display("FAIL ext_hold: got e=%0d v=%0b d=%0b want 100 0 1",
                     energy, e_valid, detect);
        end
    endtask

    task automatic test_hysteresis();
        int on0;
        feed(60, -60, 64, 0);
        @(negedge clk);
        tests++;
        if (detect !== 1'b1 || energy !== 9'd60) begin
            fails++;
            $display("FAIL hyst_stay_active: got d=%0b e=%0d want 1 60", detect, energy);
        end
        feed(0, 0, 64, 0);
        feed(60, -60, 64, 0);
        feed(60, -60, 64, 0);
        on0 = on_cnt;
        feed(60, -60, 64, 0);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (detect !== 1'b0 || on_cnt != on0) begin
            fails++;
            $display("FAIL hyst_stay_quiet: got d=%0b onsets=%0d want 0 0",
                     detect, on_cnt - on0);
        end
    endtask

    task automatic test_async_reset();
        int ev0;
        feed(100, -100, 64, 0);
        @(negedge clk);
        feed(100, 100, 30, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests++;
        if ({energy, e_valid, detect, onset} !== 12'h000) begin
            fails++;
            $display("FAIL areset_outputs: got e=%0d v=%0b d=%0b o=%0b want all 0",
                     energy, e_valid, detect, onset);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ev0 = ev_cnt;
        feed(100, -100, 63, 0);
        @(negedge clk);
        tests++;
        if (ev_cnt != ev0 || energy !== 9'd0) begin
            fails++;
            $display("FAIL areset_partial: got ev=%0d e=%0d want 0 0", ev_cnt - ev0, energy);
        end
        feed(100, -100, 1, 0);
        tests++;
        if (e_valid !== 1'b1 || energy !== 9'd100) begin
            fails++;
            $display("FAIL areset_window: got v=%0b e=%0d want 1 100", e_valid, energy);
        end
        @(negedge clk);
        tests++;
        if (onset !== 1'b1 || detect !== 1'b1) begin
            fails++;
            $display("FAIL areset_onset: got o=%0b d=%0b want 1 1", onset, detect);
        end
    endtask

    task automatic test_gaps();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        test_onset(5, "gaps");
    endtask

    initial begin
        test_reset();
        test_onset(0, "onset");
        test_holdoff();
        test_extremes();
        test_hysteresis();
        test_async_reset();
        test_gaps();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
